// File: rtl/axi_lsu_dma_arb_2to1_pkg.sv
// Shared types and constants for the LSU/DMA 2:1 AXI merge.
// Owner encoding doubles as the MSB that is prepended to the slave-side ID.
package axi_arb_pkg;

  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bit position of the owner flag inside a slave-side ID.
  function automatic int owner_bit(input int s_id_width);
    return s_id_width - 1;
  endfunction

endpackage

// File: rtl/axi_lsu_dma_arb_2to1_rr2.sv
// Two-way address-channel arbiter: round-robin (or m0 fixed priority when
// AXI_ARB_M0_PRIORITY_EN is defined), grant locked while the slave stalls.
module axi_arb_rr2
  import axi_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset_l,
  input  logic   req0,
  input  logic   req1,
  input  logic   en,
  input  logic   ready,
  output logic   valid,
  output owner_e owner
);

  logic   lock;
  owner_e lock_owner;
  owner_e pick;

`ifndef AXI_ARB_M0_PRIORITY_EN
  owner_e last;
`endif

  // Select the owner: a stalled grant must not move until its handshake.
  always_comb begin
    pick = OWN_M0;
    if (lock) begin
      pick = lock_owner;
    end else if (req0 && req1) begin
`ifdef AXI_ARB_M0_PRIORITY_EN
      pick = OWN_M0;
`else
      pick = (last == OWN_M1) ? OWN_M0 : OWN_M1;
`endif
    end else if (req1) begin
      pick = OWN_M1;
    end else begin
      pick = OWN_M0;
    end
  end

  assign owner = pick;
  assign valid = en & ((pick == OWN_M1) ? req1 : req0);

  // Lock tracking: set on a stalled valid, released by the handshake.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      lock       <= 1'b0;
      lock_owner <= OWN_M0;
    end else if (valid && ready) begin
      lock       <= 1'b0;
    end else if (valid) begin
      lock       <= 1'b1;
      lock_owner <= pick;
    end
  end

`ifndef AXI_ARB_M0_PRIORITY_EN
  // Last-grant history; reset to m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      last <= OWN_M1;
    end else if (valid && ready) begin
      last <= pick;
    end
  end
`endif

endmodule

// File: rtl/axi_lsu_dma_arb_2to1.sv
// 2:1 AXI merge of LSU (m0) and DMA/debug (m1) onto one slave; owner rides in
// the slave ID MSB. Build option: AXI_ARB_M0_PRIORITY_EN (fixed m0 priority).
module axi_lsu_dma_arb_2to1
  import axi_arb_pkg::*;
#(
  parameter int M_ID_WIDTH  = 8,
  parameter int S_ID_WIDTH  = M_ID_WIDTH + 1,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  m0_arvalid,
  input  logic [M_ID_WIDTH-1:0] m0_arid,
  input  logic [31:0]           m0_araddr,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [63:0]           m0_rdata,
  output logic [M_ID_WIDTH-1:0] m0_rid,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  input  logic                  m0_rready,
  input  logic                  m0_awvalid,
  input  logic [M_ID_WIDTH-1:0] m0_awid,
  input  logic [31:0]           m0_awaddr,
  output logic                  m0_awready,
  input  logic                  m0_wvalid,
  input  logic [63:0]           m0_wdata,
  input  logic [7:0]            m0_wstrb,
  output logic                  m0_wready,
  output logic                  m0_bvalid,
  output logic [M_ID_WIDTH-1:0] m0_bid,
  output logic [1:0]            m0_bresp,
  input  logic                  m0_bready,
  input  logic                  m1_arvalid,
  input  logic [M_ID_WIDTH-1:0] m1_arid,
  input  logic [31:0]           m1_araddr,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [63:0]           m1_rdata,
  output logic [M_ID_WIDTH-1:0] m1_rid,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  input  logic                  m1_rready,
  input  logic                  m1_awvalid,
  input  logic [M_ID_WIDTH-1:0] m1_awid,
  input  logic [31:0]           m1_awaddr,
  output logic                  m1_awready,
  input  logic                  m1_wvalid,
  input  logic [63:0]           m1_wdata,
  input  logic [7:0]            m1_wstrb,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  output logic [M_ID_WIDTH-1:0] m1_bid,
  output logic [1:0]            m1_bresp,
  input  logic                  m1_bready,
  output logic                  s_arvalid,
  output logic [S_ID_WIDTH-1:0] s_arid,
  output logic [31:0]           s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [63:0]           s_rdata,
  input  logic [S_ID_WIDTH-1:0] s_rid,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  output logic                  s_rready,
  output logic                  s_awvalid,
  output logic [S_ID_WIDTH-1:0] s_awid,
  output logic [31:0]           s_awaddr,
  input  logic                  s_awready,
  output logic                  s_wvalid,
  output logic [63:0]           s_wdata,
  output logic [7:0]            s_wstrb,
  output logic                  s_wlast,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  input  logic [S_ID_WIDTH-1:0] s_bid,
  input  logic [1:0]            s_bresp,
  output logic                  s_bready
);

  localparam int OB    = owner_bit(S_ID_WIDTH);
  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic   ar_valid, aw_valid;
  owner_e ar_owner, aw_owner;

  logic [WFIFO_DEPTH-1:0] fifo_own;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       cnt;
  logic                   full, empty, push, pop;
  owner_e                 head;
  logic                   r_own, b_own;

  // ---------------- AR ----------------
  axi_arb_rr2 u_ar_arb (
    .clk     (clk),
    .reset_l (reset_l),
    .req0    (m0_arvalid),
    .req1    (m1_arvalid),
    .en      (reset_l),
    .ready   (s_arready),
    .valid   (ar_valid),
    .owner   (ar_owner)
  );

  assign s_arvalid  = ar_valid;
  assign s_arid     = {ar_owner, (ar_owner == OWN_M1) ? m1_arid : m0_arid};
  assign s_araddr   = (ar_owner == OWN_M1) ? m1_araddr : m0_araddr;
  assign m0_arready = ar_valid & s_arready & (ar_owner == OWN_M0);
  assign m1_arready = ar_valid & s_arready & (ar_owner == OWN_M1);

  // ---------------- AW (held off while every owner slot is taken) ----------------
  assign full  = (cnt == CNT_W'(WFIFO_DEPTH));
  assign empty = (cnt == {CNT_W{1'b0}});

  axi_arb_rr2 u_aw_arb (
    .clk     (clk),
    .reset_l (reset_l),
    .req0    (m0_awvalid),
    .req1    (m1_awvalid),
    .en      (reset_l & ~full),
    .ready   (s_awready),
    .valid   (aw_valid),
    .owner   (aw_owner)
  );

  assign s_awvalid  = aw_valid;
  assign s_awid     = {aw_owner, (aw_owner == OWN_M1) ? m1_awid : m0_awid};
  assign s_awaddr   = (aw_owner == OWN_M1) ? m1_awaddr : m0_awaddr;
  assign m0_awready = aw_valid & s_awready & (aw_owner == OWN_M0);
  assign m1_awready = aw_valid & s_awready & (aw_owner == OWN_M1);

  // ---------------- W steered by accepted-AW order ----------------
  assign push = aw_valid & s_awready;
  assign pop  = s_wvalid & s_wready;
  assign head = owner_e'(fifo_own[rd_ptr]);

  assign s_wvalid  = reset_l & ~empty & ((head == OWN_M1) ? m1_wvalid : m0_wvalid);
  assign s_wdata   = (head == OWN_M1) ? m1_wdata : m0_wdata;
  assign s_wstrb   = (head == OWN_M1) ? m1_wstrb : m0_wstrb;
  assign s_wlast   = 1'b1;
  assign m0_wready = reset_l & ~empty & (head == OWN_M0) & s_wready;
  assign m1_wready = reset_l & ~empty & (head == OWN_M1) & s_wready;

  // Owner FIFO: pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      fifo_own <= {WFIFO_DEPTH{1'b0}};
      wr_ptr   <= {PTR_W{1'b0}};
      rd_ptr   <= {PTR_W{1'b0}};
      cnt      <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        fifo_own[wr_ptr] <= aw_owner;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------- R / B routed by owner bit ----------------
  assign r_own     = s_rid[OB];
  assign m0_rvalid = reset_l & s_rvalid & ~r_own;
  assign m1_rvalid = reset_l & s_rvalid & r_own;
  assign m0_rid    = s_rid[M_ID_WIDTH-1:0];
  assign m1_rid    = s_rid[M_ID_WIDTH-1:0];
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m1_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m1_rlast  = s_rlast;
  assign s_rready  = reset_l & (r_own ? m1_rready : m0_rready);

  assign b_own     = s_bid[OB];
  assign m0_bvalid = reset_l & s_bvalid & ~b_own;
  assign m1_bvalid = reset_l & s_bvalid & b_own;
  assign m0_bid    = s_bid[M_ID_WIDTH-1:0];
  assign m1_bid    = s_bid[M_ID_WIDTH-1:0];
  assign m0_bresp  = s_bresp;
  assign m1_bresp  = s_bresp;
  assign s_bready  = reset_l & (b_own ? m1_bready : m0_bready);

endmodule

// File: tb/tb_axi_lsu_dma_arb_2to1.sv
// Directed bench for axi_lsu_dma_arb_2to1: arbitration, lock, W ordering,
// owner FIFO full, R/B routing and mid-operation reset.
module tb_axi_lsu_dma_arb_2to1;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [7:0]  m0_arid, m1_arid;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, m0_rready, m1_rready;
  logic [63:0] m0_rdata, m1_rdata;
  logic [7:0]  m0_rid, m1_rid;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_awvalid, m1_awvalid, m0_awready, m1_awready;
  logic [7:0]  m0_awid, m1_awid;
  logic [31:0] m0_awaddr, m1_awaddr;
  logic        m0_wvalid, m1_wvalid, m0_wready, m1_wready;
  logic [63:0] m0_wdata, m1_wdata;
  logic [7:0]  m0_wstrb, m1_wstrb;
  logic        m0_bvalid, m1_bvalid, m0_bready, m1_bready;
  logic [7:0]  m0_bid, m1_bid;
  logic [1:0]  m0_bresp, m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [8:0]  s_arid, s_rid, s_awid, s_bid;
  logic [31:0] s_araddr, s_awaddr;
  logic [63:0] s_rdata, s_wdata;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [7:0]  s_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  axi_lsu_dma_arb_2to1 dut (
    .clk(clk), .reset_l(reset_l),
    .m0_arvalid(m0_arvalid), .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rid(m0_rid), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m0_awvalid(m0_awvalid), .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bready(m0_bready),
    .m1_arvalid(m1_arvalid), .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rid(m1_rid), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_arid(s_arid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_l = 1'b0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_arid = 8'h11; m1_arid = 8'h22;
    m0_araddr = 32'h0000_1000; m1_araddr = 32'h0000_2000;
    m0_rready = 1'b0; m1_rready = 1'b0;
    m0_awvalid = 1'b0; m1_awvalid = 1'b0; m0_awid = 8'h50; m1_awid = 8'h40;
    m0_awaddr = 32'h0000_3000; m1_awaddr = 32'h0000_4000;
    m0_wvalid = 1'b0; m1_wvalid = 1'b0; m0_wdata = 64'h0; m1_wdata = 64'h0;
    m0_wstrb = 8'hFF; m1_wstrb = 8'h0F;
    m0_bready = 1'b0; m1_bready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 64'h0; s_rid = 9'h000;
    s_rresp = 2'b00; s_rlast = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b0; s_bid = 9'h000; s_bresp = 2'b00;

    // Reset: outputs idle even with requests pending on every side
    step();
    m0_arvalid = 1'b1; s_arready = 1'b1; s_rvalid = 1'b1; m0_rready = 1'b1;
    #1;
    check("rst_s_arvalid", 64'(s_arvalid), 64'h0);
    check("rst_m0_arready", 64'(m0_arready), 64'h0);
    check("rst_m0_rvalid", 64'(m0_rvalid), 64'h0);
    check("rst_s_rready", 64'(s_rready), 64'h0);
    step();
    reset_l = 1'b1;
    m0_arvalid = 1'b0; s_rvalid = 1'b0; m0_rready = 1'b0;

    // Tie: m0 first, then m1
    step();
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
    #1;
    check("tie1_s_arid", 64'(s_arid), 64'h011);
    check("tie1_s_araddr", 64'(s_araddr), 64'h1000);
    check("tie1_m0_arready", 64'(m0_arready), 64'h1);
    check("tie1_m1_arready", 64'(m1_arready), 64'h0);
    step();
    check("tie2_s_arid", 64'(s_arid), 64'h122);
    check("tie2_m1_arready", 64'(m1_arready), 64'h1);
    check("tie2_m0_arready", 64'(m0_arready), 64'h0);

    // Lock: m1 stalled, m0 (tie winner by round-robin) joins, grant stays m1
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    #1;
    check("lock1_s_arid", 64'(s_arid), 64'h122);
    step();
    m0_arvalid = 1'b1;
    #1;
    check("lock2_s_arid", 64'(s_arid), 64'h122);
    check("lock2_m0_arready", 64'(m0_arready), 64'h0);
    step();
    check("lock3_s_arid", 64'(s_arid), 64'h122);
    s_arready = 1'b1;
    #1;
    check("lock_hs_m1_arready", 64'(m1_arready), 64'h1);
    step();
    m1_arvalid = 1'b0;
    #1;
    check("after_lock_s_arid", 64'(s_arid), 64'h011);
    step();
    m0_arvalid = 1'b0; s_arready = 1'b0;

    // Owner FIFO fill from m1, 5th AW held until one W drains
    m1_awvalid = 1'b1; s_awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m1_awid = 8'h40 + 8'(i);
      #1;
      check($sformatf("fill%0d_m1_awready", i), 64'(m1_awready), 64'h1);
      step();
    end
    m1_awid = 8'h44;
    #1;
    check("full_m1_awready", 64'(m1_awready), 64'h0);
    check("full_s_awvalid", 64'(s_awvalid), 64'h0);
    m1_wvalid = 1'b1; m1_wdata = 64'hA5A5_0000_0000_0001; s_wready = 1'b1;
    #1;
    check("full_m1_wready", 64'(m1_wready), 64'h1);
    check("full_s_wdata", s_wdata, 64'hA5A5_0000_0000_0001);
    check("full_s_wlast", 64'(s_wlast), 64'h1);
    step();
    m1_wvalid = 1'b0;
    #1;
    check("fifth_m1_awready", 64'(m1_awready), 64'h1);
    check("fifth_s_awid", 64'(s_awid), 64'h144);
    step();
    m1_awvalid = 1'b0; m1_wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("drain%0d_m1_wready", i), 64'(m1_wready), 64'h1);
      step();
    end
    check("empty_s_wvalid", 64'(s_wvalid), 64'h0);
    check("empty_m1_wready", 64'(m1_wready), 64'h0);
    m1_wvalid = 1'b0;

    // W order follows AW order: m0 then m1
    m0_awvalid = 1'b1;
    #1;
    check("ord_m0_awready", 64'(m0_awready), 64'h1);
    check("ord_s_awid", 64'(s_awid), 64'h050);
    step();
    m0_awvalid = 1'b0; m1_awvalid = 1'b1; m1_awid = 8'h41;
    m1_wvalid = 1'b1; m1_wdata = 64'h1111_2222_3333_4444;
    #1;
    check("ord_m1_awready", 64'(m1_awready), 64'h1);
    check("ord_early_m1_wready", 64'(m1_wready), 64'h0);
    check("ord_early_s_wvalid", 64'(s_wvalid), 64'h0);
    step();
    m1_awvalid = 1'b0; m0_wvalid = 1'b1; m0_wdata = 64'hDEAD_BEEF_0000_0000;
    #1;
    check("ord_w0_s_wdata", s_wdata, 64'hDEAD_BEEF_0000_0000);
    check("ord_w0_s_wstrb", 64'(s_wstrb), 64'hFF);
    check("ord_w0_m0_wready", 64'(m0_wready), 64'h1);
    check("ord_w0_m1_wready", 64'(m1_wready), 64'h0);
    step();
    m0_wvalid = 1'b0;
    #1;
    check("ord_w1_s_wdata", s_wdata, 64'h1111_2222_3333_4444);
    check("ord_w1_m1_wready", 64'(m1_wready), 64'h1);
    step();
    m1_wvalid = 1'b0; s_awready = 1'b0;

    // R and B routing by owner bit
    s_rvalid = 1'b1; s_rid = 9'h13C; s_rdata = 64'h0123_4567_89AB_CDEF; s_rlast = 1'b1;
    m1_rready = 1'b0; m0_rready = 1'b1;
    #1;
    check("r1_m1_rvalid", 64'(m1_rvalid), 64'h1);
    check("r1_m1_rid", 64'(m1_rid), 64'h3C);
    check("r1_s_rready", 64'(s_rready), 64'h0);
    check("r1_m0_rvalid", 64'(m0_rvalid), 64'h0);
    check("r1_m1_rdata", m1_rdata, 64'h0123_4567_89AB_CDEF);
    s_rid = 9'h055;
    #1;
    check("r0_m0_rvalid", 64'(m0_rvalid), 64'h1);
    check("r0_m0_rid", 64'(m0_rid), 64'h55);
    check("r0_s_rready", 64'(s_rready), 64'h1);
    check("r0_m1_rvalid", 64'(m1_rvalid), 64'h0);
    s_rvalid = 1'b0; m0_rready = 1'b0;
    s_bvalid = 1'b1; s_bid = 9'h107; s_bresp = 2'b10; m1_bready = 1'b1;
    #1;
    check("b1_m1_bvalid", 64'(m1_bvalid), 64'h1);
    check("b1_m1_bid", 64'(m1_bid), 64'h07);
    check("b1_m1_bresp", 64'(m1_bresp), 64'h2);
    check("b1_s_bready", 64'(s_bready), 64'h1);
    check("b1_m0_bvalid", 64'(m0_bvalid), 64'h0);
    step();
    s_bvalid = 1'b0; m1_bready = 1'b0;

    // Mid-operation reset: FIFO entry, m1 AR lock and a read burst in flight
    m0_awvalid = 1'b1; s_awready = 1'b1;
    step();
    m0_awvalid = 1'b0; s_awready = 1'b0;
    m1_arvalid = 1'b1; s_arready = 1'b0;
    step();
    s_rvalid = 1'b1; s_rid = 9'h13C; m1_rready = 1'b1;
    #1;
    check("pre_rst_m1_rvalid", 64'(m1_rvalid), 64'h1);
    reset_l = 1'b0;
    #1;
    check("rst_mid_m1_rvalid", 64'(m1_rvalid), 64'h0);
    check("rst_mid_s_rready", 64'(s_rready), 64'h0);
    check("rst_mid_s_arvalid", 64'(s_arvalid), 64'h0);
    m0_wvalid = 1'b1; s_wready = 1'b1;
    #1;
    check("rst_mid_s_wvalid", 64'(s_wvalid), 64'h0);
    step();
    reset_l = 1'b1; s_rvalid = 1'b0;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
    #1;
    check("post_rst_s_arid", 64'(s_arid), 64'h011);
    check("post_rst_m0_arready", 64'(m0_arready), 64'h1);
    check("post_rst_s_wvalid", 64'(s_wvalid), 64'h0);
    check("post_rst_m0_wready", 64'(m0_wready), 64'h0);
    step();
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_wvalid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
